// File: rtl/data_memory_sized_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_sized_if
// Brief    : Request/response bundle for the sized data memory.
// Revision : 1.0
// ============================================================================
interface data_memory_sized_if #(
  parameter int W = 32,
  parameter int N = 8
);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [N-1:0] req_addr;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_sized.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_sized
// Brief    : Byte-addressed data memory with sub-word access and wait states.
// Revision : 1.0
// ============================================================================
module data_memory_sized #(
  parameter int W    = 32,
  parameter int N    = 8,
  parameter int WAIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  data_memory_sized_if.slave bus
);
  localparam int         c_BYTES     = W / 8;
  localparam int         c_OFFW      = $clog2(c_BYTES);
  localparam int         c_WORDS     = (2 ** N) / c_BYTES;
  localparam logic [3:0] c_WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [7:0] c_WBITS     = 8'(W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0] r_mem [c_WORDS];

  logic         r_we;
  logic         r_unsigned;
  logic [N-1:0] r_addr;
  logic [1:0]   r_size;
  logic [W-1:0] r_wdata;
  logic [3:0]   r_cnt;
  logic [W-1:0] r_rsp_rdata;
  logic         r_rsp_err;

  logic w_ready;
  logic w_rsp_valid;
  logic w_accept;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) w_state_nxt = (WAIT > 0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP: begin
        w_rsp_valid = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = w_ready & bus.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'd0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_we       <= bus.req_we;
      r_unsigned <= bus.req_unsigned;
      r_addr     <= bus.req_addr;
      r_size     <= bus.req_size;
      r_wdata    <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                      r_cnt <= 4'd0;
    else if (w_accept)                            r_cnt <= c_WAIT_LOAD;
    else if (r_state == S_WAIT && r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;
  end

  // ---------------------------------------------------------- datapath
  logic [c_OFFW-1:0]   w_off;
  logic [N-c_OFFW-1:0] w_idx;
  logic [c_OFFW+2:0]   w_lane_sh;
  logic [3:0]          w_nbytes;
  logic [6:0]          w_nbits;
  logic [W-1:0]        w_lmask;
  logic [W-1:0]        w_topbit;
  logic [W-1:0]        w_word;
  logic [W-1:0]        w_shift;
  logic                w_sign;
  logic [W-1:0]        w_load;
  logic [W-1:0]        w_smask;
  logic [W-1:0]        w_sdata;
  logic [W-1:0]        w_merged;
  logic                w_misaligned;
  logic                w_illegal;
  logic                w_fault;

  assign w_off     = r_addr[c_OFFW-1:0];
  assign w_idx     = r_addr[N-1:c_OFFW];
  assign w_lane_sh = {w_off, 3'b000};
  assign w_nbytes  = 4'd1 << r_size;
  assign w_nbits   = {w_nbytes, 3'b000};

  // Operand mask covers the low 8*(1<<size) bits; all ones for full width.
  assign w_lmask  = {W{1'b1}} >> (c_WBITS - {1'b0, w_nbits});
  assign w_topbit = w_lmask ^ (w_lmask >> 1);

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> w_lane_sh;
  assign w_sign  = ~r_unsigned & (|(w_shift & w_topbit));
  assign w_load  = (w_shift & w_lmask) | (w_sign ? ~w_lmask : '0);

  // Aligned accesses never straddle a word, so one row read-modify-write suffices.
  assign w_smask  = w_lmask << w_lane_sh;
  assign w_sdata  = (r_wdata & w_lmask) << w_lane_sh;
  assign w_merged = (w_word & ~w_smask) | (w_sdata & w_smask);

  always_comb begin
    w_misaligned = 1'b0;
    case (r_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = r_addr[0];
      2'd2:    w_misaligned = |r_addr[1:0];
      default: w_misaligned = |r_addr[2:0];
    endcase
  end

  assign w_illegal = (r_size == 2'd3) && (W == 32);
  assign w_fault   = w_misaligned | w_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_WORDS; i++) r_mem[i] <= '0;
    end else if (r_state == S_ACCESS && r_we && !w_fault) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == S_ACCESS) begin
      r_rsp_rdata <= (w_fault || r_we) ? '0 : w_load;
      r_rsp_err   <= w_fault;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_data_memory_sized.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_sized
// Brief    : Randomized bench for data_memory_sized against a byte-array model.
// Revision : 1.0
// ============================================================================
module tb_data_memory_sized;
  localparam int c_W    = 32;
  localparam int c_N    = 8;
  localparam int c_WAIT = 2;

  logic clk = 1'b0;
  logic rst;

  data_memory_sized_if #(.W(c_W), .N(c_N)) bus ();

  data_memory_sized #(.W(c_W), .N(c_N), .WAIT(c_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  byte unsigned ref_mem [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Byte-level model: the memory is just 256 bytes, accesses are loops over them.
  function automatic void ref_access(input bit we, input int addr, input int size,
                                     input bit uns, input logic [63:0] wdata,
                                     output logic [63:0] rdata, output bit err);
    int nb;
    nb    = 1 << size;
    rdata = '0;
    err   = 1'b0;
    if ((addr % nb) != 0 || (size == 3 && c_W == 32)) begin
      err = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rdata[8*i +: 8] = ref_mem[addr + i];
      if (!uns && nb * 8 < c_W && rdata[8*nb - 1])
        for (int b = 8 * nb; b < c_W; b++) rdata[b] = 1'b1;
    end
  endfunction

  task automatic do_req(input string tag, input bit we, input int addr, input int size,
                        input bit uns, input logic [63:0] wdata);
    logic [63:0] exp_data;
    bit          exp_err;
    logic [63:0] wtmp;
    int          cnt;
    ref_access(we, addr, size, uns, wdata, exp_data, exp_err);
    wtmp = wdata;
    cnt  = 0;
    @(negedge clk);
    while (!bus.req_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " ready"}, bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = 8'(addr);
    bus.req_size     = 2'(size);
    bus.req_unsigned = uns;
    bus.req_wdata    = wtmp[c_W-1:0];
    @(negedge clk);
    bus.req_valid = 1'b0;
    cnt = 0;
    while (!bus.rsp_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " latency"}, cnt, c_WAIT + 1);
    chk({tag, " rdata"}, bus.rsp_rdata, exp_data);
    chk({tag, " err"}, bus.rsp_err, exp_err);
    @(negedge clk);
    chk({tag, " pulse/ready"}, {bus.rsp_valid, bus.req_ready}, 2'b01);
  endtask

  initial begin
    logic [63:0] q_data [$];
    bit          q_err  [$];
    logic [63:0] e_data;
    bit          e_err;
    int          n_acc;
    int          n_rsp;
    int          n_bad;
    int          sz;
    int          ad;

    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", bus.req_ready, 1);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rdata", bus.rsp_rdata, 0);
    chk("reset err", bus.rsp_err, 0);
    rst = 1'b0;

    do_req("ld 0x10", 0, 'h10, 2, 0, 0);
    do_req("st w 0x20", 1, 'h20, 2, 0, 64'h8899AABB);
    do_req("st b 0x21", 1, 'h21, 0, 0, 64'hF0);
    do_req("ld w 0x20", 0, 'h20, 2, 0, 0);
    do_req("ld b 0x21 s", 0, 'h21, 0, 0, 0);
    do_req("ld b 0x21 u", 0, 'h21, 0, 1, 0);
    do_req("ld h 0x22 s", 0, 'h22, 1, 0, 0);
    do_req("st h 0x23 misal", 1, 'h23, 1, 0, 64'hDEAD);
    do_req("ld w 0x20 again", 0, 'h20, 2, 0, 0);
    do_req("ld d illegal", 0, 'h20, 3, 0, 0);

    // Reset one cycle after a store is accepted: store must be dropped.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_addr     = 8'h30;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst ready", bus.req_ready, 1);
    n_bad = 0;
    repeat (8) begin
      if (bus.rsp_valid) n_bad++;
      @(negedge clk);
    end
    chk("midrst no rsp", n_bad, 0);
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    do_req("midrst ld 0x30", 0, 'h30, 2, 0, 0);

    // Continuous req_valid with a fresh request every cycle.
    n_acc = 0;
    n_rsp = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        n_rsp++;
        if (q_data.size() == 0) chk("hold unexpected rsp", 1, 0);
        else begin
          chk("hold rdata", bus.rsp_rdata, q_data.pop_front());
          chk("hold err", bus.rsp_err, q_err.pop_front());
        end
      end
      sz = $urandom_range(0, 3);
      ad = 'h40 + $urandom_range(0, 31);
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'($urandom_range(0, 1));
      bus.req_addr     = 8'(ad);
      bus.req_size     = 2'(sz);
      bus.req_unsigned = 1'($urandom_range(0, 1));
      bus.req_wdata    = $urandom;
      if (bus.req_ready) begin
        ref_access(bus.req_we, ad, sz, bus.req_unsigned, 64'(bus.req_wdata), e_data, e_err);
        q_data.push_back(e_data);
        q_err.push_back(e_err);
        n_acc++;
      end
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        n_rsp++;
        if (q_data.size() == 0) chk("hold unexpected rsp", 1, 0);
        else begin
          chk("hold rdata", bus.rsp_rdata, q_data.pop_front());
          chk("hold err", bus.rsp_err, q_err.pop_front());
        end
      end
    end
    chk("hold rsp count", n_rsp, n_acc);
    chk("hold expected accepts", n_acc, 80 / (c_WAIT + 3));

    // Random mix, mostly aligned, over a small region so loads see stores.
    for (int t = 0; t < 150; t++) begin
      sz = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) ad = $urandom_range(0, 255);
      else ad = $urandom_range(0, 63) & ~((1 << sz) - 1);
      do_req("rand", 1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)),
             {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
